// File: rtl/spi_sample_reader_if.sv
// Handshake and SPI pin bundle between a host and spi_sample_reader.
// The slave modport is the reader's view; master is the host/link side.
interface spi_sample_reader_if;
    logic        start;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        spi_clk;
    logic        mosi;
    logic        miso;
    logic        byte_done;
    logic [39:0] frame_out;
    logic        frame_valid;

    modport slave (
        input  start, cmd_byte, miso,
        output busy, spi_clk, mosi, byte_done, frame_out, frame_valid
    );

    modport master (
        output start, cmd_byte, miso,
        input  busy, spi_clk, mosi, byte_done, frame_out, frame_valid
    );
endinterface

// File: rtl/spi_sample_reader.sv
// Mode-0 SPI master that reads one 40-bit {time, pins} record from the
// logic-analyser slave per start request, MSB byte first.
module spi_sample_reader #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_sample_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  gap_q, gap_d;
    logic [4:0]  tog_q, tog_d;
    logic [2:0]  idx_q, idx_d;
    logic [39:0] asm_q, asm_d;
    logic [39:0] frame_q, frame_d;
    logic        spi_clk_q, spi_clk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        byte_done_q, byte_done_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            tog_q       <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            frame_q     <= '0;
            spi_clk_q   <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            tog_q       <= tog_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            frame_q     <= frame_d;
            spi_clk_q   <= spi_clk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        div_d       = div_q;
        gap_d       = gap_q;
        tog_d       = tog_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        frame_d     = frame_q;
        spi_clk_d   = spi_clk_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        byte_done_d = 1'b0;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    cmd_d   = bus.cmd_byte;
                    tx_d    = bus.cmd_byte;
                    idx_d   = '0;
                    asm_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                mosi_d  = tx_q[7];
                tx_d    = {tx_q[6:0], 1'b0};
                div_d   = DIV_RELOAD;
                tog_d   = '0;
                state_d = SHIFT;
            end

            SHIFT: begin
                if (div_q == 8'd0) begin
                    div_d     = DIV_RELOAD;
                    spi_clk_d = ~spi_clk_q;
                    tog_d     = tog_q + 5'd1;
                    if (!spi_clk_q) begin
                        rx_d = {rx_q[6:0], bus.miso};
                    end else if (tog_q == 5'd15) begin
                        // Final falling edge: rx_q already holds all eight bits.
                        mosi_d      = 1'b0;
                        byte_done_d = 1'b1;
                        case (idx_q)
                            3'd0:    asm_d[39:32] = rx_q;
                            3'd1:    asm_d[31:24] = rx_q;
                            3'd2:    asm_d[23:16] = rx_q;
                            3'd3:    asm_d[15:8]  = rx_q;
                            3'd4:    asm_d[7:0]   = rx_q;
                            default: ;
                        endcase
                        if (idx_q < 3'd4) begin
                            if (GAP_CYCLES == 0) begin
                                idx_d   = idx_q + 3'd1;
                                tx_d    = cmd_q;
                                state_d = LOAD;
                            end else begin
                                gap_d   = GAP_RELOAD;
                                state_d = GAP;
                            end
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end

            GAP: begin
                mosi_d = 1'b0;
                if (gap_q == 8'd0) begin
                    idx_d   = idx_q + 3'd1;
                    tx_d    = cmd_q;
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            // frame_out and frame_valid register here, so they appear in the
            // first IDLE cycle; busy still covers that cycle.
            DONE: begin
                frame_d = asm_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.spi_clk     = spi_clk_q;
    assign bus.mosi        = mosi_q;
    assign bus.byte_done   = byte_done_q;
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = valid_q;
endmodule

// File: tb/tb_spi_sample_reader.sv
// Bench for spi_sample_reader: two instances (default timing and fastest
// timing) each talking to a mode-0 SPI slave model that serves a 40-bit word.
module tb_spi_sample_reader;
    localparam int DIV_A = 4;
    localparam int GAP_A = 8;
    localparam int DIV_B = 1;
    localparam int GAP_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [1:0]  start_r = '0;
    logic [7:0]  cmd_r [2];
    logic [39:0] slave_word [2];
    int          arm_fall [2];
    int          arm_rise [2];

    logic [1:0]  sclk_w, mosi_w, miso_w, busy_w, bd_w, fv_w;
    logic [39:0] fo_w [2];
    int          rise_w [2];
    int          fall_w [2];
    int          bd_cnt_w [2];
    int          fv_cnt_w [2];
    int          unstable_w [2];
    logic [39:0] mosi_log_w [2];

    spi_sample_reader_if bus_a ();
    spi_sample_reader_if bus_b ();

    spi_sample_reader #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_sample_reader #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_a.start    = start_r[0];
    assign bus_a.cmd_byte = cmd_r[0];
    assign bus_a.miso     = miso_w[0];
    assign bus_b.start    = start_r[1];
    assign bus_b.cmd_byte = cmd_r[1];
    assign bus_b.miso     = miso_w[1];

    assign sclk_w = {bus_b.spi_clk,     bus_a.spi_clk};
    assign mosi_w = {bus_b.mosi,        bus_a.mosi};
    assign busy_w = {bus_b.busy,        bus_a.busy};
    assign bd_w   = {bus_b.byte_done,   bus_a.byte_done};
    assign fv_w   = {bus_b.frame_valid, bus_a.frame_valid};
    assign fo_w[0] = bus_a.frame_out;
    assign fo_w[1] = bus_b.frame_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: bit k of the served word sits on miso after k falling edges.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        int          rise_cnt = 0;
        int          fall_cnt = 0;
        int          bd_cnt = 0;
        int          fv_cnt = 0;
        int          unstable = 0;
        int          sidx;
        logic [39:0] mosi_log = '0;
        logic [39:0] shifted;
        logic        prev_sclk = 1'b0;
        logic        prev_mosi = 1'b0;

        always @(posedge sclk_w[g]) begin
            rise_cnt <= rise_cnt + 1;
            mosi_log <= {mosi_log[38:0], mosi_w[g]};
        end

        always @(negedge sclk_w[g]) fall_cnt <= fall_cnt + 1;

        always @(posedge clk) begin
            #1;
            if (bd_w[g]) bd_cnt++;
            if (fv_w[g]) fv_cnt++;
            if (sclk_w[g] && !prev_sclk && (mosi_w[g] !== prev_mosi)) unstable++;
            prev_sclk = sclk_w[g];
            prev_mosi = mosi_w[g];
        end

        assign sidx          = fall_cnt - arm_fall[g];
        assign shifted       = slave_word[g] << sidx;
        assign miso_w[g]     = shifted[39];
        assign rise_w[g]     = rise_cnt;
        assign fall_w[g]     = fall_cnt;
        assign bd_cnt_w[g]   = bd_cnt;
        assign fv_cnt_w[g]   = fv_cnt;
        assign unstable_w[g] = unstable;
        assign mosi_log_w[g] = mosi_log;
    end

    function automatic int ref_latency(input int d);
        int div = (d == 0) ? DIV_A : DIV_B;
        int gap = (d == 0) ? GAP_A : GAP_B;
        return 5 * (1 + 16 * div) + 4 * gap + 1;
    endfunction

    task automatic arm(input int d, input logic [39:0] word);
        slave_word[d] = word;
        arm_fall[d]   = fall_w[d];
        arm_rise[d]   = rise_w[d];
    endtask

    task automatic wait_valid(input int d, output int t);
        t = -1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (fv_w[d]) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic run_frame(input int d, input logic [39:0] word, input logic [7:0] cmd,
                             input string tag);
        int t0, t_fv, bd0, fv0;
        logic [39:0] exp_mosi;
        exp_mosi = {5{cmd}};
        arm(d, word);
        bd0 = bd_cnt_w[d];
        fv0 = fv_cnt_w[d];
        @(negedge clk);
        start_r[d] = 1'b1;
        cmd_r[d]   = cmd;
        @(posedge clk);
        #1;
        t0         = cyc;
        start_r[d] = 1'b0;
        cmd_r[d]   = 8'($urandom);
        n_cmp++;
        if (busy_w[d] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s busy_after_start: got %b, expected 1", tag, busy_w[d]);
        end
        wait_valid(d, t_fv);
        n_cmp++;
        if (t_fv < 0) begin
            n_bad++;
            $display("[TB] FAIL %s latency: frame_valid timeout, expected %0d", tag, ref_latency(d));
        end else if (t_fv - t0 != ref_latency(d)) begin
            n_bad++;
            $display("[TB] FAIL %s latency: got %0d, expected %0d", tag, t_fv - t0, ref_latency(d));
        end
        n_cmp++;
        if (fo_w[d] !== word) begin
            n_bad++;
            $display("[TB] FAIL %s frame_out: got %h, expected %h", tag, fo_w[d], word);
        end
        n_cmp++;
        if (busy_w[d] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s busy_at_valid: got %b, expected 1", tag, busy_w[d]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({fv_w[d], busy_w[d]} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL %s after_valid {valid,busy}: got %b, expected 00", tag, {fv_w[d], busy_w[d]});
        end
        n_cmp++;
        if (bd_cnt_w[d] - bd0 != 5) begin
            n_bad++;
            $display("[TB] FAIL %s byte_done_count: got %0d, expected 5", tag, bd_cnt_w[d] - bd0);
        end
        n_cmp++;
        if (fv_cnt_w[d] - fv0 != 1) begin
            n_bad++;
            $display("[TB] FAIL %s valid_count: got %0d, expected 1", tag, fv_cnt_w[d] - fv0);
        end
        n_cmp++;
        if (rise_w[d] - arm_rise[d] != 40) begin
            n_bad++;
            $display("[TB] FAIL %s spi_clk_rises: got %0d, expected 40", tag, rise_w[d] - arm_rise[d]);
        end
        n_cmp++;
        if (mosi_log_w[d] !== exp_mosi) begin
            n_bad++;
            $display("[TB] FAIL %s mosi_bits: got %h, expected %h", tag, mosi_log_w[d], exp_mosi);
        end
    endtask

    task automatic test_reset();
        int activity = 0;
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({sclk_w[d], mosi_w[d], busy_w[d], bd_w[d], fv_w[d]} !== 5'b0 || fo_w[d] !== 40'h0) begin
                n_bad++;
                $display("[TB] FAIL reset_outputs dut%0d: got sclk=%b mosi=%b busy=%b bd=%b fv=%b fo=%h, expected all 0",
                         d, sclk_w[d], mosi_w[d], busy_w[d], bd_w[d], fv_w[d], fo_w[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if ((sclk_w | mosi_w | busy_w | fv_w | bd_w) != 2'b00) activity++;
        end
        n_cmp++;
        if (activity != 0 || fv_cnt_w[0] + fv_cnt_w[1] != 0) begin
            n_bad++;
            $display("[TB] FAIL idle_quiet: got %0d active cycles and %0d valids, expected 0",
                     activity, fv_cnt_w[0] + fv_cnt_w[1]);
        end
    endtask

    task automatic test_basic_frame();
        run_frame(0, 40'h12345678A5, 8'h00, "basic");
    endtask

    task automatic test_cmd_pattern();
        run_frame(0, {$urandom, 8'($urandom)}, 8'hC3, "cmd_c3");
    endtask

    task automatic test_fast_timing();
        run_frame(1, 40'hFF00AA5501, 8'($urandom), "fast");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 3; i++) begin
            run_frame(0, {$urandom, 8'($urandom)}, 8'($urandom), "rand_a");
            run_frame(1, {$urandom, 8'($urandom)}, 8'($urandom), "rand_b");
        end
    endtask

    task automatic test_back_to_back();
        int t0, t, fv0, r0;
        logic [39:0] w1, w2, w3;
        w1 = {$urandom, 8'($urandom)};
        w2 = {$urandom, 8'($urandom)};
        w3 = {$urandom, 8'($urandom)};
        // Start held through the whole frame and the DONE edge, dropped after valid.
        arm(0, w1);
        fv0 = fv_cnt_w[0];
        r0  = rise_w[0];
        @(negedge clk);
        start_r[0] = 1'b1;
        cmd_r[0]   = 8'h5A;
        @(posedge clk);
        #1;
        t0 = cyc;
        wait_valid(0, t);
        start_r[0] = 1'b0;
        n_cmp++;
        if (t < 0 || t - t0 != ref_latency(0)) begin
            n_bad++;
            $display("[TB] FAIL b2b_first_latency: got %0d, expected %0d", t - t0, ref_latency(0));
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_w[0] !== 1'b0 || fv_cnt_w[0] - fv0 != 1 || rise_w[0] - r0 != 40 || fo_w[0] !== w1) begin
            n_bad++;
            $display("[TB] FAIL b2b_single_frame: got busy=%b valids=%0d rises=%0d fo=%h, expected 0/1/40/%h",
                     busy_w[0], fv_cnt_w[0] - fv0, rise_w[0] - r0, fo_w[0], w1);
        end
        // Start kept high into the first IDLE cycle launches a second frame.
        arm(0, w2);
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_valid(0, t);
        n_cmp++;
        if (t < 0 || fo_w[0] !== w2) begin
            n_bad++;
            $display("[TB] FAIL b2b_frame_a: got %h, expected %h", fo_w[0], w2);
        end
        arm(0, w3);
        @(posedge clk);
        #1;
        t0 = cyc;
        start_r[0] = 1'b0;
        n_cmp++;
        if (busy_w[0] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL b2b_idle_accept busy: got %b, expected 1", busy_w[0]);
        end
        wait_valid(0, t);
        n_cmp++;
        if (t < 0 || t - t0 != ref_latency(0) || fo_w[0] !== w3) begin
            n_bad++;
            $display("[TB] FAIL b2b_frame_b: got lat=%0d fo=%h, expected lat=%0d fo=%h",
                     t - t0, fo_w[0], ref_latency(0), w3);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int bd0, fv0, n;
        arm(0, {$urandom, 8'($urandom)});
        bd0 = bd_cnt_w[0];
        fv0 = fv_cnt_w[0];
        @(negedge clk);
        start_r[0] = 1'b1;
        cmd_r[0]   = 8'($urandom);
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        n = 0;
        while (bd_cnt_w[0] - bd0 < 3 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (sclk_w[0] !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n >= 2000) begin
            n_bad++;
            $display("[TB] FAIL midreset_reach_byte3: got timeout, expected spi_clk high after 3 bytes");
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({sclk_w[0], mosi_w[0], busy_w[0], bd_w[0], fv_w[0]} !== 5'b0 || fo_w[0] !== 40'h0) begin
            n_bad++;
            $display("[TB] FAIL midreset_clear: got sclk=%b mosi=%b busy=%b bd=%b fv=%b fo=%h, expected all 0",
                     sclk_w[0], mosi_w[0], busy_w[0], bd_w[0], fv_w[0], fo_w[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        n_cmp++;
        if (fv_cnt_w[0] != fv0 || busy_w[0] !== 1'b0 || fo_w[0] !== 40'h0) begin
            n_bad++;
            $display("[TB] FAIL midreset_no_frame: got valids=%0d busy=%b fo=%h, expected 0/0/0",
                     fv_cnt_w[0] - fv0, busy_w[0], fo_w[0]);
        end
        run_frame(0, {$urandom, 8'($urandom)}, 8'($urandom), "after_reset");
    endtask

    initial begin
        cmd_r[0] = 8'h00;
        cmd_r[1] = 8'h00;
        slave_word[0] = '0;
        slave_word[1] = '0;
        arm_fall[0] = 0;
        arm_fall[1] = 0;
        arm_rise[0] = 0;
        arm_rise[1] = 0;
        test_reset();
        test_basic_frame();
        test_cmd_pattern();
        test_fast_timing();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (unstable_w[d] != 0) begin
                n_bad++;
                $display("[TB] FAIL mosi_stable dut%0d: got %0d changes at rising edges, expected 0",
                         d, unstable_w[d]);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
